mdu_control: RTL

Parametrised sequencing controller for the iterative shift-add multiplier / shift-subtract divider datapath. It replaces the fixed 32-iteration divide-only controller. Width, the multiply/divide mode, an edge-started Run/Ready handshake and divide-by-zero detection are all run-time or elaboration-time choices. It sits beside the datapath registers and ALU, steering load, write, ALU opcode and shift strobes each cycle.

---
 rtl/mdu_pkg.sv | 19 +
 rtl/mdu_iter_counter.sv | 38 +++
 rtl/mdu_control.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide sequencing controller:
// ALU opcodes, operating-mode encodings and the controller state type.
package mdu_pkg;

  localparam logic [5:0] Addu = 6'b001001;
  localparam logic [5:0] Subu = 6'b001010;

  localparam logic MODE_DIV = 1'b0;
  localparam logic MODE_MUL = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ITER,
    FIX,
    DONE
  } mdu_state_t;

endpackage

// File: rtl/mdu_iter_counter.sv
// Iteration counter for the shift-add / shift-subtract loop. It is cleared
// while operands load, advances once per iteration and flags the final one.
module mdu_iter_counter #(
  parameter int WIDTH = 32,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic en_i,
  output logic last_o
);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Clear has priority so a fresh operation always starts counting from zero.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + CW'(1);
    end
  end

  // Counter register, forced to zero whenever the controller is reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign last_o = (count_q == CW'(WIDTH - 1));

endmodule

// File: rtl/mdu_control.sv
// Sequencing controller for the iterative multiplier / divider datapath.
// A rising edge on Run starts an operation (only when idle or finished);
// the controller loads operands, runs WIDTH iterations, applies the divide
// fix-up shift and reports Ready, flagging divide-by-zero on Error.
module mdu_control
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       Reset_n,
  input  logic       Run,
  input  logic       Mode,
  input  logic       Sign,
  input  logic       Lsb,
  input  logic       Dvz,
  output logic       Load,
  output logic       W_ctrl,
  output logic [5:0] ALU_ctrl,
  output logic       SLL_ctrl,
  output logic       SRL_ctrl,
  output logic       Busy,
  output logic       Ready,
  output logic       Error
);

  localparam int CW = $clog2(WIDTH);

  mdu_state_t state_q;
  mdu_state_t state_d;
  logic       run_q;
  logic       mode_q;
  logic       mode_d;
  logic       error_q;
  logic       error_d;
  logic       startAccept;
  logic       iterLast;

  assign startAccept = Run & ~run_q & ((state_q == IDLE) || (state_q == DONE));

  mdu_iter_counter #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_iter_counter (
    .clk_i   (clk),
    .rst_ni  (Reset_n),
    .clear_i (state_q == LOAD),
    .en_i    (state_q == ITER),
    .last_o  (iterLast)
  );

  // State, edge-detect, latched mode and error flag registers.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      run_q   <= 1'b0;
      mode_q  <= MODE_DIV;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= Run;
      mode_q  <= mode_d;
      error_q <= error_d;
    end
  end

  // Next-state logic; mode and error only change on a start or in LOAD.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    error_d = error_q;
    case (state_q)
      IDLE, DONE: begin
        if (startAccept) begin
          state_d = LOAD;
          mode_d  = Mode;
          error_d = 1'b0;
        end
      end
      LOAD: begin
        if ((mode_q == MODE_DIV) && Dvz) begin
          error_d = 1'b1;
          state_d = DONE;
        end else begin
          state_d = ITER;
        end
      end
      ITER: begin
        if (iterLast) begin
          state_d = (mode_q == MODE_DIV) ? FIX : DONE;
        end
      end
      FIX: begin
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Moore output decode; only the ITER write strobe follows Sign/Lsb directly.
  always_comb begin
    Load     = 1'b0;
    W_ctrl   = 1'b0;
    ALU_ctrl = 6'b0;
    SLL_ctrl = 1'b0;
    SRL_ctrl = 1'b0;
    Busy     = 1'b0;
    Ready    = 1'b0;
    case (state_q)
      LOAD: begin
        Load = 1'b1;
        Busy = 1'b1;
      end
      ITER: begin
        Busy = 1'b1;
        if (mode_q == MODE_DIV) begin
          ALU_ctrl = Subu;
          W_ctrl   = ~Sign;
          SLL_ctrl = 1'b1;
        end else begin
          ALU_ctrl = Addu;
          W_ctrl   = Lsb;
          SRL_ctrl = 1'b1;
        end
      end
      FIX: begin
        Busy     = 1'b1;
        SRL_ctrl = 1'b1;
      end
      DONE: begin
        Ready = 1'b1;
      end
      default: begin
        Busy = 1'b0;
      end
    endcase
  end

  assign Error = error_q;

endmodule
